dff_response_checker: RTL and testbench
=======================================

Name: dff_response_checker

Overview:
Sequential checker for the receive end of a flip-flop stimulus/response interface. It watches the D stimulus applied to a DFF under test and that DFF's Q. It keeps a reference copy of D delayed by the expected latency, compares every cycle, and records mismatch statistics. It sits next to the DFF under test in simulation and in on-board self-test builds, and is fully synthesizable.

Parameters:
LATENCY, 1, clock edges between D being sampled and Q reflecting it; legal 1..8
CNT_W, 16, width of all counters and indices
STOP_ON_ERR, 0, 1 = freeze checking in FAIL on first mismatch; 0 = keep counting

Ports:
clk  input  1  rising-edge clock shared with the DFF under test
rest  input  1  synchronous, active-high reset
en  input  1  checking enable; low flushes the reference pipeline
d_in  input  1  stimulus bit driven onto the DFF's D
q_obs  input  1  DFF's Q output
primed  output  1  high while in CHECK, i.e. each cycle is a compare cycle
mismatch  output  1  one-cycle pulse, registered, one cycle after a failed compare
chk_cnt  output  CNT_W  number of compares performed, saturating
err_cnt  output  CNT_W  number of failed compares, saturating
first_err_valid  output  1  sticky; high once any mismatch has been recorded
first_err_idx  output  CNT_W  value of chk_cnt at the first failing compare
fail_latched  output  1  high in FAIL state

Behaviour:
- Reset: when rest is high at a rising edge, all outputs go to 0, the reference shift register exp_sr[LATENCY-1:0] goes to 0, the fill counter goes to 0, and the state goes to IDLE. Reset takes priority over every other event, including mid-CHECK and in FAIL.
- Sampling: all inputs are sampled on the rising edge of clk.
  - At each edge with en=1 (outside FAIL), exp_sr shifts in d_in.
  - exp_sr[LATENCY-1] is d_in as sampled LATENCY edges earlier.
- Compare rule: at edge k in CHECK, q_obs(k) is compared with exp_sr[LATENCY-1].
  - For a plain DFF, q sampled at edge k equals D sampled at edge k-1, so LATENCY=1 matches it.
- State IDLE:
  - primed=0; no compare.
  - en=1 → PRIME; the d_in sampled on that edge is the first value shifted in, and the fill counter becomes 1.
- State PRIME:
  - Shifts d_in in and increments the fill counter each en=1 edge.
  - When the fill counter reaches LATENCY → CHECK; primed=1 from the next cycle.
  - With LATENCY=1, CHECK is entered one edge after en rises.
  - en=0 → IDLE and the fill counter clears.
- State CHECK:
  - Each edge: chk_cnt increments.
  - On q_obs != exp_sr[LATENCY-1]: err_cnt increments and mismatch=1 on the next cycle.
  - If first_err_valid=0, first_err_idx is loaded with the pre-increment chk_cnt and first_err_valid is set.
  - en=0 → IDLE; no compare on that edge; exp_sr and the fill counter clear. chk_cnt, err_cnt and first_err_* are retained.
- State FAIL (STOP_ON_ERR=1 only):
  - Entered on the edge of the first mismatch; that mismatch is still counted and pulsed.
  - fail_latched=1; no shifting, no counting, en ignored.
  - Exited only by rest.
- Saturation: chk_cnt and err_cnt hold at 2^CNT_W-1. A compare made while chk_cnt is saturated still updates err_cnt.
- Simultaneous en=0 and mismatch: en=0 wins; no compare occurs on that edge.
- Invariant: err_cnt <= chk_cnt at all times.
- X handling: q_obs of X/Z counts as a mismatch (use case-inequality semantics in simulation).

Test Plan:
1. LATENCY=1, reset for 2 cycles, then en=1 with the real DFF and d_in=0,1,0,1,0,1,1,0 → primed high from the 2nd en cycle, chk_cnt=7, err_cnt=0, mismatch never pulses.
2. Same as scenario 1, but q_obs forced inverted on the 4th compare → single mismatch pulse one cycle later, err_cnt=1, first_err_valid=1, first_err_idx=3.
3. STOP_ON_ERR=1 with q_obs tied to 0 and d_in=1 constant → fail_latched=1 after the first compare, err_cnt=1, chk_cnt=1, counts frozen for 10 further cycles; rest clears everything.
4. LATENCY=3 with a 3-stage DFF chain and random d_in for 50 cycles → primed after 3 en edges, chk_cnt=47, err_cnt=0.
5. en dropped for 2 cycles mid-CHECK, then reasserted → IDLE, re-PRIME for LATENCY edges; counters continue from prior values; no spurious mismatch.
6. CNT_W=4, continuous mismatches for 20 cycles → chk_cnt=15 and err_cnt=15 held; rest asserted mid-run → all outputs 0 on the next cycle.

Source files
------------

// File: rtl/dff_response_checker.sv
// Response checker for a DFF under test: delays D by LATENCY edges, compares
// against the observed Q every cycle and keeps saturating pass/fail statistics.
module dff_response_checker #(
  parameter int unsigned LATENCY     = 1,
  parameter int unsigned CNT_W       = 16,
  parameter bit          STOP_ON_ERR = 1'b0
) (
  input  logic             clk,
  input  logic             rest,
  input  logic             en,
  input  logic             d_in,
  input  logic             q_obs,
  output logic             primed,
  output logic             mismatch,
  output logic [CNT_W-1:0] chk_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             first_err_valid,
  output logic [CNT_W-1:0] first_err_idx,
  output logic             fail_latched
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PRIME = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;
  localparam logic [1:0] ST_FAIL  = 2'd3;

  localparam logic [3:0] FILL_TGT = 4'(LATENCY);

  logic [1:0]         state_q, state_d;
  logic [3:0]         fill_q, fill_d;
  logic [LATENCY-1:0] exp_sr_q, exp_sr_d;
  logic [CNT_W-1:0]   chk_q, chk_d;
  logic [CNT_W-1:0]   err_q, err_d;
  logic [CNT_W-1:0]   fidx_q, fidx_d;
  logic               fev_q, fev_d;
  logic               mism_q, mism_d;

  logic [LATENCY:0]   sr_ext;
  logic [LATENCY-1:0] exp_shift;
  logic [3:0]         fill_inc;
  logic               miss;

  // Concatenate then truncate so the shift is legal for LATENCY=1 too.
  assign sr_ext    = {exp_sr_q, d_in};
  assign exp_shift = sr_ext[LATENCY-1:0];
  assign fill_inc  = fill_q + 4'd1;
  // Case inequality: an X/Z on q_obs is a failure, not a silent pass.
  assign miss      = (q_obs !== exp_sr_q[LATENCY-1]);

  always_comb begin
    state_d  = state_q;
    fill_d   = fill_q;
    exp_sr_d = exp_sr_q;
    chk_d    = chk_q;
    err_d    = err_q;
    fidx_d   = fidx_q;
    fev_d    = fev_q;
    mism_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (en) begin
          exp_sr_d = exp_shift;
          fill_d   = 4'd1;
          state_d  = (FILL_TGT == 4'd1) ? ST_CHECK : ST_PRIME;
        end else begin
          exp_sr_d = '0;
          fill_d   = '0;
        end
      end
      ST_PRIME: begin
        if (en) begin
          exp_sr_d = exp_shift;
          fill_d   = fill_inc;
          if (fill_inc == FILL_TGT) state_d = ST_CHECK;
        end else begin
          exp_sr_d = '0;
          fill_d   = '0;
          state_d  = ST_IDLE;
        end
      end
      ST_CHECK: begin
        if (en) begin
          exp_sr_d = exp_shift;
          if (chk_q != '1) chk_d = chk_q + 1'b1;
          if (miss) begin
            if (err_q != '1) err_d = err_q + 1'b1;
            mism_d = 1'b1;
            if (!fev_q) begin
              fev_d  = 1'b1;
              fidx_d = chk_q;
            end
            if (STOP_ON_ERR) state_d = ST_FAIL;
          end
        end else begin
          exp_sr_d = '0;
          fill_d   = '0;
          state_d  = ST_IDLE;
        end
      end
      ST_FAIL: ;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rest) begin
      state_q  <= ST_IDLE;
      fill_q   <= '0;
      exp_sr_q <= '0;
      chk_q    <= '0;
      err_q    <= '0;
      fidx_q   <= '0;
      fev_q    <= 1'b0;
      mism_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      fill_q   <= fill_d;
      exp_sr_q <= exp_sr_d;
      chk_q    <= chk_d;
      err_q    <= err_d;
      fidx_q   <= fidx_d;
      fev_q    <= fev_d;
      mism_q   <= mism_d;
    end
  end

  assign primed          = (state_q == ST_CHECK);
  assign fail_latched    = (state_q == ST_FAIL);
  assign mismatch        = mism_q;
  assign chk_cnt         = chk_q;
  assign err_cnt         = err_q;
  assign first_err_valid = fev_q;
  assign first_err_idx   = fidx_q;

endmodule

// File: tb/tb_dff_response_checker.sv
// Directed bench for dff_response_checker: four instances cover plain DFF,
// stop-on-error, a 3-deep chain with en gaps, and narrow-counter saturation.
module tb_dff_response_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // u1: LATENCY=1 against a real DFF, with optional Q inversion
  logic rst1 = 1'b1, en1 = 1'b0, d1 = 1'b0, inv1 = 1'b0, ff1;
  logic pr1, mm1, fev1, fl1;
  logic [15:0] chk1, err1, fidx1;
  always @(posedge clk) ff1 <= d1;
  dff_response_checker #(.LATENCY(1), .CNT_W(16), .STOP_ON_ERR(1'b0)) u1 (
    .clk(clk), .rest(rst1), .en(en1), .d_in(d1), .q_obs(ff1 ^ inv1),
    .primed(pr1), .mismatch(mm1), .chk_cnt(chk1), .err_cnt(err1),
    .first_err_valid(fev1), .first_err_idx(fidx1), .fail_latched(fl1));

  // u2: STOP_ON_ERR=1 with Q stuck at 0
  logic rst2 = 1'b1, en2 = 1'b0, d2 = 1'b0;
  logic pr2, mm2, fev2, fl2;
  logic [15:0] chk2, err2, fidx2;
  dff_response_checker #(.LATENCY(1), .CNT_W(16), .STOP_ON_ERR(1'b1)) u2 (
    .clk(clk), .rest(rst2), .en(en2), .d_in(d2), .q_obs(1'b0),
    .primed(pr2), .mismatch(mm2), .chk_cnt(chk2), .err_cnt(err2),
    .first_err_valid(fev2), .first_err_idx(fidx2), .fail_latched(fl2));

  // u3: LATENCY=3 against a 3-stage DFF chain
  logic rst3 = 1'b1, en3 = 1'b0, d3 = 1'b0;
  logic [2:0] ch3;
  logic pr3, mm3, fev3, fl3;
  logic [15:0] chk3, err3, fidx3;
  always @(posedge clk) ch3 <= {ch3[1:0], d3};
  dff_response_checker #(.LATENCY(3), .CNT_W(16), .STOP_ON_ERR(1'b0)) u3 (
    .clk(clk), .rest(rst3), .en(en3), .d_in(d3), .q_obs(ch3[2]),
    .primed(pr3), .mismatch(mm3), .chk_cnt(chk3), .err_cnt(err3),
    .first_err_valid(fev3), .first_err_idx(fidx3), .fail_latched(fl3));

  // u4: CNT_W=4 against an inverting DFF
  logic rst4 = 1'b1, en4 = 1'b0, d4 = 1'b0, ff4;
  logic pr4, mm4, fev4, fl4;
  logic [3:0] chk4, err4, fidx4;
  always @(posedge clk) ff4 <= d4;
  dff_response_checker #(.LATENCY(1), .CNT_W(4), .STOP_ON_ERR(1'b0)) u4 (
    .clk(clk), .rest(rst4), .en(en4), .d_in(d4), .q_obs(~ff4),
    .primed(pr4), .mismatch(mm4), .chk_cnt(chk4), .err_cnt(err4),
    .first_err_valid(fev4), .first_err_idx(fidx4), .fail_latched(fl4));

  logic [7:0] pat = 8'b0110_1010;

  initial begin
    // Scenario 1: clean run
    tick(); tick();
    check_val("s1_rst_primed", pr1, 0);
    check_val("s1_rst_mm", mm1, 0);
    check_val("s1_rst_chk", chk1, 0);
    check_val("s1_rst_err", err1, 0);
    check_val("s1_rst_fev", fev1, 0);
    check_val("s1_rst_fidx", fidx1, 0);
    check_val("s1_rst_fail", fl1, 0);
    rst1 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      d1 = pat[i]; en1 = 1'b1; inv1 = 1'b0;
      tick();
      check_val("s1_primed", pr1, 1);
      check_val("s1_mm", mm1, 0);
    end
    check_val("s1_chk", chk1, 7);
    check_val("s1_err", err1, 0);
    check_val("s1_fev", fev1, 0);

    // Scenario 2: inverted Q on the 4th compare
    en1 = 1'b0; rst1 = 1'b1;
    tick(); tick();
    check_val("s2_rst_chk", chk1, 0);
    rst1 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      d1 = pat[i]; en1 = 1'b1; inv1 = (i == 4);
      tick();
      check_val("s2_mm", mm1, (i == 4));
    end
    inv1 = 1'b0;
    check_val("s2_chk", chk1, 7);
    check_val("s2_err", err1, 1);
    check_val("s2_fev", fev1, 1);
    check_val("s2_fidx", fidx1, 3);
    en1 = 1'b0; rst1 = 1'b1;

    // Scenario 3: stop on first error
    tick(); tick();
    rst2 = 1'b0; d2 = 1'b1; en2 = 1'b1;
    tick();
    check_val("s3_primed", pr2, 1);
    check_val("s3_chk0", chk2, 0);
    check_val("s3_fail0", fl2, 0);
    tick();
    check_val("s3_fail", fl2, 1);
    check_val("s3_mm", mm2, 1);
    check_val("s3_chk", chk2, 1);
    check_val("s3_err", err2, 1);
    check_val("s3_fev", fev2, 1);
    check_val("s3_fidx", fidx2, 0);
    check_val("s3_primed_off", pr2, 0);
    for (int i = 0; i < 10; i++) begin
      en2 = i[0];
      tick();
      check_val("s3_hold_chk", chk2, 1);
      check_val("s3_hold_err", err2, 1);
      check_val("s3_hold_mm", mm2, 0);
      check_val("s3_hold_fail", fl2, 1);
    end
    en2 = 1'b1; rst2 = 1'b1;
    tick();
    check_val("s3_clr_fail", fl2, 0);
    check_val("s3_clr_chk", chk2, 0);
    check_val("s3_clr_err", err2, 0);
    check_val("s3_clr_fev", fev2, 0);
    check_val("s3_clr_primed", pr2, 0);

    // Scenario 4: LATENCY=3 chain with random data
    rst3 = 1'b1;
    tick(); tick();
    rst3 = 1'b0;
    for (int i = 0; i < 50; i++) begin
      d3 = 1'($urandom_range(1, 0)); en3 = 1'b1;
      tick();
      if (i == 1) check_val("s4_primed_early", pr3, 0);
      if (i == 2) check_val("s4_primed", pr3, 1);
      check_val("s4_mm", mm3, 0);
    end
    check_val("s4_chk", chk3, 47);
    check_val("s4_err", err3, 0);

    // Scenario 5: en gap mid-CHECK, re-prime, counters continue
    en3 = 1'b0;
    tick();
    check_val("s5_idle", pr3, 0);
    tick();
    check_val("s5_gap_chk", chk3, 47);
    for (int j = 0; j < 3; j++) begin
      d3 = 1'($urandom_range(1, 0)); en3 = 1'b1;
      tick();
      check_val("s5_reprime", pr3, (j == 2));
      check_val("s5_reprime_mm", mm3, 0);
    end
    check_val("s5_prime_chk", chk3, 47);
    for (int j = 0; j < 5; j++) begin
      d3 = 1'($urandom_range(1, 0));
      tick();
      check_val("s5_mm", mm3, 0);
    end
    check_val("s5_chk", chk3, 52);
    check_val("s5_err", err3, 0);
    check_val("s5_fev", fev3, 0);
    en3 = 1'b0; rst3 = 1'b1;

    // Scenario 6: 4-bit counter saturation, then reset mid-run
    tick(); tick();
    rst4 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      d4 = i[0]; en4 = 1'b1;
      tick();
      if (i == 9) begin
        check_val("s6_mid_chk", chk4, 9);
        check_val("s6_mid_err", err4, 9);
      end
    end
    check_val("s6_chk_sat", chk4, 15);
    check_val("s6_err_sat", err4, 15);
    check_val("s6_mm", mm4, 1);
    check_val("s6_fev", fev4, 1);
    check_val("s6_fidx", fidx4, 0);
    rst4 = 1'b1;
    tick();
    check_val("s6_rst_chk", chk4, 0);
    check_val("s6_rst_err", err4, 0);
    check_val("s6_rst_mm", mm4, 0);
    check_val("s6_rst_primed", pr4, 0);
    check_val("s6_rst_fev", fev4, 0);
    check_val("s6_rst_fidx", fidx4, 0);
    check_val("s6_rst_fail", fl4, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
